cmp_share_arb: RTL and testbench

Shares one registered equality/inequality compare unit (the `eq`/`neq` primitive family) between `NREQ` requesters. Each requester presents a 1-bit valid, two `WIDTH`-bit operands and an op select. The block arbitrates, latches the winner's operands, evaluates, and returns a tagged 1-bit result over a valid/ready response channel. It sits between compiler-generated datapath lanes and a single physical comparator, so several logical compares map onto one LUT-based unit.

---
 rtl/cmp_share_arb.sv | 157 +++++++++++++++
 tb/tb_cmp_share_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_share_arb.sv
// ---------------------------------------------------------------------------
// cmp_share_arb
//
// Shares one registered equal / not-equal compare unit between NREQ
// requesters. An arbiter picks one pending requester while idle, its
// operands are latched, the compare is evaluated in the following cycle and
// the tagged 1-bit result is offered on a valid/ready response channel.
//
// Configuration macro:
//   CMP_SHARE_ARB_RR_EN  defined   -> round-robin arbitration (pointer built)
//                        undefined -> fixed priority, lowest index wins
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req_valid  in   [NREQ]        requester i has a compare pending
//   req_ready  out  [NREQ]        one-hot grant, combinational while idle
//   req_a      in   [NREQ*WIDTH]  operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   [NREQ*WIDTH]  operand b, same packing
//   req_neq    in   [NREQ]        1 = not-equal compare, 0 = equal compare
//   rsp_valid  out  1             result available
//   rsp_ready  in   1             consumer accepts the result
//   rsp_id     out  [IDW]         requester that owns the result
//   rsp_y      out  1             compare result
//   cmp_count  out  16            completed response handshakes, wraps
// ---------------------------------------------------------------------------
module cmp_share_arb #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   input  logic [NREQ-1:0]         req_neq,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IDW-1:0]          rsp_id,
   output logic                    rsp_y,
   output logic [15:0]             cmp_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             neq_r;

   logic             any_s;
   logic [IDW-1:0]   win_s;

`ifdef CMP_SHARE_ARB_RR_EN
   logic [IDW-1:0]   ptr_r;
`endif

   // y is the not-equal result when neq=1 and the equal result when neq=0
   function automatic logic cmp_eval(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic             neq);
      return (a != b) ^ ~neq;
   endfunction

   // Arbiter: scan from the start index, wrapping, first valid requester wins
   always_comb begin
      int   start;
      int   idx;
      logic found;
      logic hit;
`ifdef CMP_SHARE_ARB_RR_EN
      start = int'(ptr_r);
`else
      start = 0;
`endif
      idx   = 0;
      found = 1'b0;
      hit   = 1'b0;
      win_s = {IDW{1'b0}};
      any_s = |req_valid;
      for (int k = 0; k < NREQ; k++) begin
         idx   = (start + k) % NREQ;
         hit   = ~found & req_valid[idx];
         win_s = hit ? IDW'(idx) : win_s;
         found = found | hit;
      end
   end

   // Grant is only offered while idle so at most one compare is in flight
   always_comb begin
      if ((state_r == ST_IDLE) && any_s) begin
         req_ready = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
      end else begin
         req_ready = {NREQ{1'b0}};
      end
   end

   // Control FSM with operand latch, result register and handshake counter
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         a_r       <= {WIDTH{1'b0}};
         b_r       <= {WIDTH{1'b0}};
         neq_r     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= {IDW{1'b0}};
         rsp_y     <= 1'b0;
         cmp_count <= 16'd0;
`ifdef CMP_SHARE_ARB_RR_EN
         ptr_r     <= {IDW{1'b0}};
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_s) begin
                  a_r     <= req_a[win_s*WIDTH +: WIDTH];
                  b_r     <= req_b[win_s*WIDTH +: WIDTH];
                  neq_r   <= req_neq[win_s];
                  rsp_id  <= win_s;
                  state_r <= ST_EXEC;
`ifdef CMP_SHARE_ARB_RR_EN
                  ptr_r   <= IDW'((int'(win_s) + 1) % NREQ);
`endif
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               rsp_y     <= cmp_eval(a_r, b_r, neq_r);
               rsp_valid <= 1'b1;
               state_r   <= ST_RESP;
            end
            ST_RESP: begin
               // Outputs hold until the consumer takes the result
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmp_count <= cmp_count + 16'd1;
                  state_r   <= ST_IDLE;
               end else begin
                  state_r   <= ST_RESP;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_share_arb.sv
// ---------------------------------------------------------------------------
// tb_cmp_share_arb
//
// Directed self-checking bench for cmp_share_arb (NREQ=4, WIDTH=8).
// Covers reset values, single equal/not-equal compares, the 1-bit truth
// table, an MSB difference, response backpressure, reset during EXEC and
// arbitration order under contention (order depends on CMP_SHARE_ARB_RR_EN).
// ---------------------------------------------------------------------------
module tb_cmp_share_arb;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic                  clock = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_neq;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic                  rsp_y;
   logic [15:0]           cmp_count;

   int                    checks = 0;
   int                    errors = 0;
   logic [15:0]           exp_count;

   cmp_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_neq   (req_neq),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .cmp_count (cmp_count)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one compare from an idle DUT and returns at the first RESP cycle
   task automatic do_cmp(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic neq, input logic exp_y, input string tag);
      @(negedge clock);
      req_a[id*WIDTH +: WIDTH] = a;
      req_b[id*WIDTH +: WIDTH] = b;
      req_neq[id]              = neq;
      req_valid                = 4'b0001 << id;
      #1;
      check_val({tag, ".grant"}, 32'(req_ready), 32'(4'b0001 << id));
      // EXEC: disturb the requester inputs so a missing latch gives ~exp_y
      @(negedge clock);
      req_valid                = 4'b0000;
      req_a[id*WIDTH +: WIDTH] = 8'h33;
      req_b[id*WIDTH +: WIDTH] = 8'h33;
      req_neq[id]              = exp_y;
      check_val({tag, ".exec_valid"}, 32'(rsp_valid), 32'd0);
      check_val({tag, ".exec_ready"}, 32'(req_ready), 32'd0);
      @(negedge clock);
      check_val({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      check_val({tag, ".rsp_id"},    32'(rsp_id),    32'(id));
      check_val({tag, ".rsp_y"},     32'(rsp_y),     32'(exp_y));
   endtask

   // Completes the handshake (rsp_ready already high) and checks the counter
   task automatic finish_cmp(input string tag);
      @(negedge clock);
      exp_count = exp_count + 16'd1;
      check_val({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
      check_val({tag, ".count"},      32'(cmp_count), 32'(exp_count));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [NREQ-1:0] gseq [0:7];
      logic [NREQ-1:0] gexp [0:4];
      int              grants;
      int              nexp;

      reset     = 1'b1;
      req_valid = 4'b0000;
      req_a     = 32'h0;
      req_b     = 32'h0;
      req_neq   = 4'b0000;
      rsp_ready = 1'b1;
      exp_count = 16'd0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Reset values
      check_val("rst.req_ready", 32'(req_ready), 32'd0);
      check_val("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("rst.rsp_id",    32'(rsp_id),    32'd0);
      check_val("rst.rsp_y",     32'(rsp_y),     32'd0);
      check_val("rst.count",     32'(cmp_count), 32'd0);

      // Single compares on requester 1
      do_cmp(1, 8'h5A, 8'h5A, 1'b1, 1'b0, "neq_same");  finish_cmp("neq_same");
      do_cmp(1, 8'h5A, 8'h5A, 1'b0, 1'b1, "eq_same");   finish_cmp("eq_same");
      do_cmp(1, 8'h5A, 8'h5B, 1'b0, 1'b0, "eq_diff");   finish_cmp("eq_diff");

      // 1-bit truth table with neq=1: 00,10,01,11 -> 0,1,1,0
      do_cmp(0, 8'h00, 8'h00, 1'b1, 1'b0, "tt00");      finish_cmp("tt00");
      do_cmp(0, 8'h01, 8'h00, 1'b1, 1'b1, "tt10");      finish_cmp("tt10");
      do_cmp(0, 8'h00, 8'h01, 1'b1, 1'b1, "tt01");      finish_cmp("tt01");
      do_cmp(0, 8'h01, 8'h01, 1'b1, 1'b0, "tt11");      finish_cmp("tt11");

      // Backpressure with an MSB-only difference; requester 3 waits meanwhile
      rsp_ready = 1'b0;
      do_cmp(2, 8'h80, 8'h00, 1'b1, 1'b1, "bp");
      req_valid = 4'b1000;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         check_val("bp.hold_valid", 32'(rsp_valid), 32'd1);
         check_val("bp.hold_id",    32'(rsp_id),    32'd2);
         check_val("bp.hold_y",     32'(rsp_y),     32'd1);
         check_val("bp.hold_ready", 32'(req_ready), 32'd0);
         check_val("bp.hold_count", 32'(cmp_count), 32'(exp_count));
      end
      rsp_ready = 1'b1;
      req_valid = 4'b0000;
      finish_cmp("bp");

      // Reset while in EXEC aborts the compare
      @(negedge clock);
      req_a[3*WIDTH +: WIDTH] = 8'h11;
      req_b[3*WIDTH +: WIDTH] = 8'h22;
      req_neq[3]              = 1'b1;
      req_valid               = 4'b1000;
      @(negedge clock);
      req_valid = 4'b0000;
      reset     = 1'b1;
      @(negedge clock);
      reset     = 1'b0;
      exp_count = 16'd0;
      check_val("mid_rst.valid", 32'(rsp_valid), 32'd0);
      check_val("mid_rst.count", 32'(cmp_count), 32'd0);
      check_val("mid_rst.id",    32'(rsp_id),    32'd0);
      check_val("mid_rst.y",     32'(rsp_y),     32'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check_val("mid_rst.no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Contention: all requesters valid continuously from a fresh pointer
`ifdef CMP_SHARE_ARB_RR_EN
      gexp[0] = 4'b0001; gexp[1] = 4'b0010; gexp[2] = 4'b0100;
      gexp[3] = 4'b1000; gexp[4] = 4'b0001;
      nexp    = 5;
`else
      gexp[0] = 4'b0001; gexp[1] = 4'b0001; gexp[2] = 4'b0001;
      gexp[3] = 4'b0001; gexp[4] = 4'b0001;
      nexp    = 3;
`endif
      for (int i = 0; i < 8; i++) gseq[i] = 4'b0000;
      grants = 0;
      req_a = 32'h0;
      req_b = 32'h0;
      @(negedge clock);
      req_valid = 4'b1111;
      for (int c = 0; c < 16; c++) begin
         #1;
         if (req_ready != 4'b0000) begin
            if (grants < 8) gseq[grants] = req_ready;
            grants++;
         end
         @(negedge clock);
      end
      req_valid = 4'b0000;
      check_val("cont.grants", 32'(grants), 32'd6);
      for (int i = 0; i < nexp; i++) begin
         check_val($sformatf("cont.order%0d", i), 32'(gseq[i]), 32'(gexp[i]));
      end
      repeat (4) @(negedge clock);
      exp_count = exp_count + 16'(grants);
      check_val("cont.count", 32'(cmp_count), 32'(exp_count));
      check_val("cont.idle_valid", 32'(rsp_valid), 32'd0);

      // One more compare after contention
      do_cmp(3, 8'hFF, 8'h7F, 1'b1, 1'b1, "final");     finish_cmp("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
